parallel_axis_playback: RTL and testbench

PARALLEL_AXIS_PLAYBACK -- requirements
Module: parallel_axis_playback

---
 rtl/parallel_axis_playback.sv | 150 +++++++++++++++
 tb/tb_parallel_axis_playback.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_axis_playback.sv
// Frame-oriented AXI-Stream playback from a beat buffer loaded while idle.
// Two-entry output queue is filled straight from the buffer's registered read.
module parallel_axis_playback #(
  parameter int SAMP_PER_CLK = 2,
  parameter int SAMP_WIDTH   = 32,
  parameter int DEPTH        = 64,
  parameter int FRAME_LEN    = 32,
  parameter int TUSER        = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_en,
  input  logic [$clog2(DEPTH)-1:0]           wr_addr,
  input  logic [SAMP_PER_CLK*SAMP_WIDTH-1:0] wr_data,
  output logic                               wr_err,
  input  logic                               start,
  input  logic                               stop,
  input  logic [15:0]                        num_frames,
  output logic                               busy,
  output logic                               done,
  output logic [SAMP_PER_CLK*SAMP_WIDTH-1:0] m_axis_tdata,
  output logic                               m_axis_tvalid,
  output logic                               m_axis_tlast,
  output logic [TUSER-1:0]                   m_axis_tuser,
  input  logic                               m_axis_tready
);
  localparam int DW = SAMP_PER_CLK * SAMP_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DRAIN} state_t;

  state_t state_q, state_d;
  logic [DW-1:0]    buf_mem  [DEPTH];
  logic [DW-1:0]    fifo_dat [2];
  logic             fifo_lst [2];
  logic [TUSER-1:0] fifo_usr [2];

  logic [1:0]       cnt_q, cnt_d;
  logic             rp_q, rp_d, wp_q, wp_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [FW-1:0]    beat_q, beat_d;
  logic [15:0]      frm_q, frm_d;
  logic [15:0]      nf_q, nf_d;
  logic [TUSER-1:0] ucnt_q, ucnt_d;
  logic             stop_q, stop_d;
  logic             wr_err_q, wr_err_d;

  logic pop, room, issue, is_last, fin;

  assign m_axis_tvalid = (cnt_q != 2'd0);
  assign m_axis_tdata  = fifo_dat[rp_q];
  assign m_axis_tlast  = m_axis_tvalid & fifo_lst[rp_q];
  assign m_axis_tuser  = m_axis_tvalid ? fifo_usr[rp_q] : '0;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DRAIN) && (cnt_q == 2'd0);
  assign wr_err        = wr_err_q;

  always_comb begin
    pop     = m_axis_tvalid & m_axis_tready;
    room    = (cnt_q != 2'd2) || pop;
    is_last = (beat_q == FW'(FRAME_LEN - 1));
    fin     = ((nf_q != 16'd0) && (frm_q == nf_q - 16'd1))
              || stop_q || stop;
    issue    = 1'b0;
    state_d  = state_q;
    addr_d   = addr_q;
    beat_d   = beat_q;
    frm_d    = frm_q;
    nf_d     = nf_q;
    ucnt_d   = ucnt_q;
    stop_d   = stop_q;
    wr_err_d = wr_en && (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PRIME;
          nf_d    = num_frames;
          stop_d  = 1'b0;
          addr_d  = '0;
          beat_d  = '0;
          frm_d   = '0;
          ucnt_d  = '0;
        end
      end
      PRIME, STREAM: begin
        stop_d  = stop_q | stop;
        issue   = room;
        state_d = STREAM;
        if (issue) begin
          addr_d = addr_q + AW'(1);
          if (is_last) begin
            beat_d = '0;
            frm_d  = frm_q + 16'd1;
            ucnt_d = ucnt_q + TUSER'(1);
            // end only on a frame boundary
            if (fin) state_d = DRAIN;
          end else begin
            beat_d = beat_q + FW'(1);
          end
        end
      end
      DRAIN: begin
        if (cnt_q == 2'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cnt_d = cnt_q + 2'(issue) - 2'(pop);
    rp_d  = rp_q ^ pop;
    wp_d  = wp_q ^ issue;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rp_q     <= 1'b0;
      wp_q     <= 1'b0;
      addr_q   <= '0;
      beat_q   <= '0;
      frm_q    <= '0;
      nf_q     <= '0;
      ucnt_q   <= '0;
      stop_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rp_q     <= rp_d;
      wp_q     <= wp_d;
      addr_q   <= addr_d;
      beat_q   <= beat_d;
      frm_q    <= frm_d;
      nf_q     <= nf_d;
      ucnt_q   <= ucnt_d;
      stop_q   <= stop_d;
      wr_err_q <= wr_err_d;
    end
  end

  // buffer and queue payload are never cleared
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == IDLE)) buf_mem[wr_addr] <= wr_data;
    if (issue) begin
      fifo_dat[wp_q] <= buf_mem[addr_q];
      fifo_lst[wp_q] <= is_last;
      fifo_usr[wp_q] <= ucnt_q;
    end
  end
endmodule

// File: tb/tb_parallel_axis_playback.sv
// Directed bench for parallel_axis_playback with a frame-level reference model.
// Monitor checks every handshake and every stall against the model.
module tb_parallel_axis_playback;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        wr_err;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] num_frames = '0;
  logic        busy, done;
  logic [63:0] tdata;
  logic        tvalid, tlast;
  logic [7:0]  tuser;
  logic        tready = 1'b1;

  parallel_axis_playback dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .start(start), .stop(stop), .num_frames(num_frames),
    .busy(busy), .done(done),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast),
    .m_axis_tuser(tuser), .m_axis_tready(tready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] model_mem [64];
  logic [63:0] got_data [256];
  logic [7:0]  got_user [256];
  int beat_idx, done_cnt, cyc, last_hs_cyc, done_cyc;
  bit mon_en = 1'b0;
  bit rand_rdy = 1'b0;
  bit prev_stall = 1'b0;
  logic [127:0] prev_pkt;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_data(input int n);
    return model_mem[n % 64];
  endfunction
  function automatic logic exp_last(input int n);
    return (n % 32) == 31;
  endfunction
  function automatic logic [7:0] exp_user(input int n);
    return 8'(n / 32);
  endfunction

  initial forever begin
    @(posedge clk); #1;
    tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    cyc++;
    if (mon_en && !rst) begin
      if (prev_stall) begin
        chk("hold_valid", 128'(tvalid), 128'(1));
        chk("hold_payload", {55'd0, tuser, tlast, tdata}, prev_pkt);
      end
      if (tvalid && tready) begin
        chk("beat_data", tdata, exp_data(beat_idx));
        chk("beat_last", 128'(tlast), 128'(exp_last(beat_idx)));
        chk("beat_user", 128'(tuser), 128'(exp_user(beat_idx)));
        if (beat_idx < 256) begin
          got_data[beat_idx] = tdata;
          got_user[beat_idx] = tuser;
        end
        beat_idx++;
        last_hs_cyc = cyc;
      end
      prev_stall = tvalid && !tready;
      prev_pkt = {55'd0, tuser, tlast, tdata};
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic load(input logic [63:0] base);
    for (int k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      wr_en = 1'b1;
      wr_addr = 6'(k);
      wr_data = base + 64'(k);
      model_mem[k] = base + 64'(k);
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    chk("idle_no_wr_err", 128'(wr_err), 128'(0));
  endtask

  task automatic run(input int nf, input int stop_at, input int exp_beats,
                     input bit wr_mid, input bit wr_with_start);
    bit stop_sent, wr_sent;
    int t;
    stop_sent = 0;
    wr_sent = 0;
    beat_idx = 0;
    done_cnt = 0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    num_frames = 16'(nf);
    start = 1'b1;
    if (wr_with_start) begin
      wr_en = 1'b1;
      wr_addr = 6'd0;
      wr_data = 64'h1234;
      model_mem[0] = 64'h1234;
    end
    @(posedge clk); #1;
    start = 1'b0;
    wr_en = 1'b0;
    @(negedge clk);
    chk("prime_valid", 128'(tvalid), 128'(0));
    chk("prime_busy", 128'(busy), 128'(1));
    @(negedge clk);
    chk("first_valid", 128'(tvalid), 128'(1));
    for (t = 0; t < 5000 && done_cnt == 0; t++) begin
      @(posedge clk); #1;
      stop = 1'b0;
      if (stop_at >= 0 && !stop_sent && beat_idx >= stop_at) begin
        stop = 1'b1;
        stop_sent = 1;
      end
      if (wr_mid && !wr_sent && beat_idx >= 8) begin
        wr_en = 1'b1;
        wr_addr = 6'd5;
        wr_data = 64'hDEAD;
        start = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("wr_err_pulse", 128'(wr_err), 128'(1));
        wr_sent = 1;
      end
    end
    stop = 1'b0;
    chk("no_timeout", 128'(done_cnt > 0), 128'(1));
    chk("beat_count", 128'(beat_idx), 128'(exp_beats));
    chk("done_lag", 128'(done_cyc - last_hs_cyc), 128'(1));
    @(negedge clk);
    chk("busy_after_done", 128'(busy), 128'(0));
    @(negedge clk);
    chk("single_done", 128'(done_cnt), 128'(1));
    chk("valid_after_done", 128'(tvalid), 128'(0));
    mon_en = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    chk("rst_valid", 128'(tvalid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_wr_err", 128'(wr_err), 128'(0));
    chk("rst_last", 128'(tlast), 128'(0));
    chk("rst_user", 128'(tuser), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    load(64'd0);
    run(2, -1, 64, 0, 0);
    chk("pin_d0", got_data[0], 64'd0);
    chk("pin_d63", got_data[63], 64'd63);
    chk("pin_u31", 128'(got_user[31]), 128'(0));
    chk("pin_u32", 128'(got_user[32]), 128'(1));

    rand_rdy = 1'b1;
    run(2, -1, 64, 0, 0);
    chk("pin_rand_d40", got_data[40], 64'd40);
    rand_rdy = 1'b0;

    run(0, 40, 64, 0, 0);

    run(3, -1, 96, 0, 0);
    chk("pin_wrap_d64", got_data[64], 64'd0);
    chk("pin_wrap_d95", got_data[95], 64'd31);
    chk("pin_wrap_u95", 128'(got_user[95]), 128'(2));

    run(1, -1, 32, 1, 0);
    run(1, -1, 32, 0, 0);
    chk("pin_unchanged_d5", got_data[5], 64'd5);

    beat_idx = 0;
    done_cnt = 0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    num_frames = 16'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < 500 && beat_idx < 10; t++) @(posedge clk);
    chk("reached_beat10", 128'(beat_idx >= 10), 128'(1));
    #1;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 128'(tvalid), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_last", 128'(tlast), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    run(1, -1, 32, 0, 0);
    chk("pin_rst_d0", got_data[0], 64'd0);
    chk("pin_rst_u0", 128'(got_user[0]), 128'(0));

    run(1, -1, 32, 0, 1);
    chk("pin_new_d0", got_data[0], 64'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
